// File: rtl/axil_pkg.sv
// axil_pkg: AXI4-Lite response codes and address constants shared by the CSR responder.
package axil_pkg;
    typedef logic [1:0] axil_resp_t;
    localparam axil_resp_t AXI_RESP_OKAY   = 2'b00;
    localparam axil_resp_t AXI_RESP_SLVERR = 2'b10;
    localparam int         ADDR_LSB        = 2;
endpackage

// File: rtl/axil_chan_buf.sv
// axil_chan_buf: single-entry valid/ready holding register with a registered ready.
// Ready is computed from next-cycle state so it can be a flop; i_block is the owner's next-cycle stall.
module axil_chan_buf #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             async_resetn,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    input  logic             i_block,
    input  logic             i_clear,
    output logic             o_ready,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data
);
    logic             r_full;
    logic             r_ready;
    logic [WIDTH-1:0] r_data;
    logic             w_take;
    logic             w_full_nxt;

    // take and clear are mutually exclusive: take needs !full, clear needs full
    assign w_take     = i_valid && r_ready;
    assign w_full_nxt = !i_clear && (r_full || w_take);

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            r_full  <= 1'b0;
            r_ready <= 1'b0;
            r_data  <= '0;
        end else begin
            r_full  <= w_full_nxt;
            r_ready <= !w_full_nxt && !i_block;
            if (w_take) r_data <= i_data;
        end
    end

    assign o_ready = r_ready;
    assign o_full  = r_full;
    assign o_data  = r_data;
endmodule

// File: rtl/axil_csr_responder.sv
// axil_csr_responder: AXI4-Lite slave exposing a small CSR bank.
// Word 0 is a read-only live status; words 1..NUM-1 are RW registers.
module axil_csr_responder
    import axil_pkg::*;
#(
    parameter int                      P_ADDR_WIDTH = 16,
    parameter int                      P_DATA_WIDTH = 32,
    parameter int                      P_NUM_REGS   = 4,
    parameter logic [P_DATA_WIDTH-1:0] P_RST_VALUE  = '0
) (
    input  logic                             clock,
    input  logic                             async_resetn,
    input  logic [P_ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                             s_axi_awvalid,
    output logic                             s_axi_awready,
    input  logic [P_DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic                             s_axi_wvalid,
    output logic                             s_axi_wready,
    output logic [1:0]                       s_axi_bresp,
    output logic                             s_axi_bvalid,
    input  logic                             s_axi_bready,
    input  logic [P_ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                             s_axi_arvalid,
    output logic                             s_axi_arready,
    output logic [P_DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [1:0]                       s_axi_rresp,
    output logic                             s_axi_rvalid,
    input  logic                             s_axi_rready,
    input  logic [P_DATA_WIDTH-1:0]          status_in,
    output logic [P_NUM_REGS*P_DATA_WIDTH-1:0] reg_out,
    output logic [P_NUM_REGS-1:0]            wr_pulse
);
    localparam int IDX_W = P_ADDR_WIDTH - ADDR_LSB;
    localparam int SEL_W = $clog2(P_NUM_REGS);

    logic [P_DATA_WIDTH-1:0] r_regs [1:P_NUM_REGS-1];
    logic                    r_bvalid;
    axil_resp_t              r_bresp;
    logic [P_NUM_REGS-1:0]   r_wr_pulse;
    logic                    r_rvalid;
    logic                    r_arready;
    axil_resp_t              r_rresp;
    logic [P_DATA_WIDTH-1:0] r_rdata;

    logic                    w_aw_full;
    logic                    w_w_full;
    logic [IDX_W-1:0]        w_aw_idx;
    logic [P_DATA_WIDTH-1:0] w_wdata;
    logic [IDX_W-1:0]        w_ar_idx;
    logic [P_DATA_WIDTH-1:0] w_ar_data;
    logic                    w_commit;
    logic                    w_aw_ok;
    logic                    w_ar_ok;
    logic                    w_ar_hs;
    logic                    w_bvalid_nxt;
    logic                    w_rvalid_nxt;
    logic                    w_unused;

    axil_chan_buf #(.WIDTH(IDX_W)) u_aw (
        .clock        (clock),
        .async_resetn (async_resetn),
        .i_data       (s_axi_awaddr[P_ADDR_WIDTH-1:ADDR_LSB]),
        .i_valid      (s_axi_awvalid),
        .i_block      (w_bvalid_nxt),
        .i_clear      (w_commit),
        .o_ready      (s_axi_awready),
        .o_full       (w_aw_full),
        .o_data       (w_aw_idx)
    );

    axil_chan_buf #(.WIDTH(P_DATA_WIDTH)) u_w (
        .clock        (clock),
        .async_resetn (async_resetn),
        .i_data       (s_axi_wdata),
        .i_valid      (s_axi_wvalid),
        .i_block      (w_bvalid_nxt),
        .i_clear      (w_commit),
        .o_ready      (s_axi_wready),
        .o_full       (w_w_full),
        .o_data       (w_wdata)
    );

    assign w_commit     = w_aw_full && w_w_full && !r_bvalid;
    assign w_aw_ok      = (w_aw_idx != '0) && (w_aw_idx < IDX_W'(P_NUM_REGS));
    assign w_bvalid_nxt = w_commit || (r_bvalid && !s_axi_bready);
    assign w_ar_idx     = s_axi_araddr[P_ADDR_WIDTH-1:ADDR_LSB];
    assign w_ar_ok      = w_ar_idx < IDX_W'(P_NUM_REGS);
    assign w_ar_hs      = s_axi_arvalid && r_arready;
    assign w_rvalid_nxt = w_ar_hs || (r_rvalid && !s_axi_rready);
    assign w_ar_data    = !w_ar_ok ? '0 : (w_ar_idx == '0) ? status_in : r_regs[w_ar_idx[SEL_W-1:0]];
    assign w_unused     = &{1'b0, s_axi_awaddr[ADDR_LSB-1:0], s_axi_araddr[ADDR_LSB-1:0]};

    // Write commit: register update, strobe and B response share one edge
    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            for (int i = 1; i < P_NUM_REGS; i++) r_regs[i] <= P_RST_VALUE;
            r_bvalid   <= 1'b0;
            r_bresp    <= AXI_RESP_OKAY;
            r_wr_pulse <= '0;
        end else begin
            if (w_commit && w_aw_ok) r_regs[w_aw_idx[SEL_W-1:0]] <= w_wdata;
            r_bvalid   <= w_bvalid_nxt;
            r_wr_pulse <= (w_commit && w_aw_ok) ? P_NUM_REGS'(1) << w_aw_idx[SEL_W-1:0] : '0;
            if (w_commit) r_bresp <= w_aw_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end
    end

    always_ff @(posedge clock or negedge async_resetn) begin
        if (!async_resetn) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b0;
            r_rresp   <= AXI_RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            r_rvalid  <= w_rvalid_nxt;
            r_arready <= !w_rvalid_nxt;
            if (w_ar_hs) begin
                r_rdata <= w_ar_data;
                r_rresp <= w_ar_ok ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
            end
        end
    end

    for (genvar k = 0; k < P_NUM_REGS; k++) begin : g_out
        if (k == 0) begin : g_ro
            assign reg_out[k*P_DATA_WIDTH +: P_DATA_WIDTH] = '0;
        end else begin : g_rw
            assign reg_out[k*P_DATA_WIDTH +: P_DATA_WIDTH] = r_regs[k];
        end
    end

    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign wr_pulse      = r_wr_pulse;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rdata   = r_rdata;
endmodule

// File: tb/tb_axil_csr_responder.sv
// tb_axil_csr_responder: scoreboard bench; stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_axil_csr_responder;
    import axil_pkg::*;

    typedef struct { logic [1:0] resp; logic [3:0] pulse; } b_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; } r_exp_t;

    logic         clock = 1'b0;
    logic         async_resetn = 1'b0;
    logic [15:0]  s_axi_awaddr = '0;
    logic         s_axi_awvalid = 1'b0;
    logic         s_axi_awready;
    logic [31:0]  s_axi_wdata = '0;
    logic         s_axi_wvalid = 1'b0;
    logic         s_axi_wready;
    logic [1:0]   s_axi_bresp;
    logic         s_axi_bvalid;
    logic         s_axi_bready = 1'b1;
    logic [15:0]  s_axi_araddr = '0;
    logic         s_axi_arvalid = 1'b0;
    logic         s_axi_arready;
    logic [31:0]  s_axi_rdata;
    logic [1:0]   s_axi_rresp;
    logic         s_axi_rvalid;
    logic         s_axi_rready = 1'b1;
    logic [31:0]  status_in = '0;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

    b_exp_t bq[$];
    r_exp_t rq[$];
    b_exp_t be;
    r_exp_t re;
    int     n_chk = 0;
    int     n_fail = 0;
    logic   prev_b = 1'b0;

    axil_csr_responder dut (
        .clock         (clock),
        .async_resetn  (async_resetn),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .status_in     (status_in),
        .reg_out       (reg_out),
        .wr_pulse      (wr_pulse)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int k);
        return reg_out[k*32 +: 32];
    endfunction

    always @(negedge clock) begin
        if (s_axi_bvalid && !prev_b) begin
            if (bq.size() == 0) check("b_unexpected", 64'(s_axi_bvalid), 64'd0);
            else check("wr_pulse", 64'(wr_pulse), 64'(bq[0].pulse));
        end else check("wr_pulse_idle", 64'(wr_pulse), 64'd0);
        if (s_axi_bvalid && s_axi_bready) begin
            if (bq.size() == 0) check("b_unexpected", 64'(s_axi_bvalid), 64'd0);
            else begin
                be = bq.pop_front();
                check("bresp", 64'(s_axi_bresp), 64'(be.resp));
            end
        end
        if (s_axi_rvalid && s_axi_rready) begin
            if (rq.size() == 0) check("r_unexpected", 64'(s_axi_rvalid), 64'd0);
            else begin
                re = rq.pop_front();
                check("rdata", 64'(s_axi_rdata), 64'(re.data));
                check("rresp", 64'(s_axi_rresp), 64'(re.resp));
            end
        end
        prev_b = s_axi_bvalid;
    end

    task automatic aw_send(input logic [15:0] a);
        int n = 0;
        s_axi_awaddr = a;
        s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 50) begin @(posedge clock); #1; n++; end
        check("aw_timeout", 64'(n >= 50), 64'd0);
        @(posedge clock); #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d);
        int n = 0;
        s_axi_wdata = d;
        s_axi_wvalid = 1'b1;
        while (!s_axi_wready && n < 50) begin @(posedge clock); #1; n++; end
        check("w_timeout", 64'(n >= 50), 64'd0);
        @(posedge clock); #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic ar_send(input logic [15:0] a);
        int n = 0;
        s_axi_araddr = a;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 50) begin @(posedge clock); #1; n++; end
        check("ar_timeout", 64'(n >= 50), 64'd0);
        @(posedge clock); #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic write(input logic [15:0] a, input logic [31:0] d);
        fork
            aw_send(a);
            w_send(d);
        join
    endtask

    task automatic wait_bvalid();
        int n = 0;
        while (!s_axi_bvalid && n < 50) begin @(posedge clock); #1; n++; end
        check("bvalid_timeout", 64'(n >= 50), 64'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((bq.size() != 0 || rq.size() != 0) && n < 100) begin @(posedge clock); #1; n++; end
        check("drain_timeout", 64'(n >= 100), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // T1: reset values, readies come up one clock after release
        #1499;
        check("rst_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
        check("rst_valid", 64'({s_axi_bvalid, s_axi_rvalid}), 64'd0);
        check("rst_resp", 64'({s_axi_bresp, s_axi_rresp}), 64'd0);
        check("rst_rdata", 64'(s_axi_rdata), 64'd0);
        check("rst_regs_lo", reg_out[63:0], 64'd0);
        check("rst_regs_hi", reg_out[127:64], 64'd0);
        #1;
        async_resetn = 1'b1;
        #1;
        check("ready_before_clk", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
        @(posedge clock); #1;
        check("ready_after_clk", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'h7);

        // T2: AW then W two cycles later
        aw_send(16'h0004);
        repeat (2) @(posedge clock);
        #1;
        bq.push_back(b_exp_t'{AXI_RESP_OKAY, 4'b0010});
        w_send(32'h0000_000C);
        drain();
        check("t2_word1", 64'(word(1)), 64'h0000_000C);

        // T3: W before AW with bready held low
        s_axi_bready = 1'b0;
        bq.push_back(b_exp_t'{AXI_RESP_OKAY, 4'b0100});
        w_send(32'hDEAD_BEEF);
        aw_send(16'h0008);
        wait_bvalid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("t3_bvalid_hold", 64'(s_axi_bvalid), 64'd1);
            check("t3_ready_low", 64'({s_axi_awready, s_axi_wready}), 64'd0);
        end
        @(posedge clock); #1;
        s_axi_bready = 1'b1;
        @(posedge clock); #1;
        check("t3_ready_back", 64'({s_axi_awready, s_axi_wready}), 64'h3);
        drain();
        check("t3_word2", 64'(word(2)), 64'hDEAD_BEEF);

        // T4: read-only word, out-of-range write and read
        bq.push_back(b_exp_t'{AXI_RESP_SLVERR, 4'b0000});
        write(16'h0000, 32'hFFFF_FFFF);
        bq.push_back(b_exp_t'{AXI_RESP_SLVERR, 4'b0000});
        write(16'h0010, 32'h1111_1111);
        rq.push_back(r_exp_t'{32'h0, AXI_RESP_SLVERR});
        ar_send(16'h0010);
        rq.push_back(r_exp_t'{32'hDEAD_BEEF, AXI_RESP_OKAY});
        ar_send(16'h000B);
        drain();
        check("t4_word0", 64'(word(0)), 64'd0);
        check("t4_word1", 64'(word(1)), 64'h0000_000C);
        check("t4_word3", 64'(word(3)), 64'd0);

        // T5: status read, then read of word 1 on the commit edge of a new write
        status_in = 32'h1234_5678;
        rq.push_back(r_exp_t'{32'h1234_5678, AXI_RESP_OKAY});
        ar_send(16'h0000);
        drain();
        bq.push_back(b_exp_t'{AXI_RESP_OKAY, 4'b0010});
        rq.push_back(r_exp_t'{32'h0000_000C, AXI_RESP_OKAY});
        fork
            aw_send(16'h0004);
            w_send(32'h0000_0055);
            begin @(posedge clock); #1; ar_send(16'h0004); end
        join
        rq.push_back(r_exp_t'{32'h0000_0055, AXI_RESP_OKAY});
        ar_send(16'h0004);
        drain();

        // T6: asynchronous reset while B is waiting
        s_axi_bready = 1'b0;
        bq.push_back(b_exp_t'{AXI_RESP_OKAY, 4'b1000});
        write(16'h000C, 32'hA5A5_A5A5);
        wait_bvalid();
        check("t6_word3_pre", 64'(word(3)), 64'hA5A5_A5A5);
        @(negedge clock); #2;
        async_resetn = 1'b0;
        #1;
        check("t6_bvalid", 64'(s_axi_bvalid), 64'd0);
        check("t6_regs_lo", reg_out[63:0], 64'd0);
        check("t6_regs_hi", reg_out[127:64], 64'd0);
        check("t6_ready", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'd0);
        bq.delete();
        s_axi_bready = 1'b1;
        #20;
        async_resetn = 1'b1;
        @(posedge clock); #1;
        check("t6_ready_back", 64'({s_axi_awready, s_axi_wready, s_axi_arready}), 64'h7);
        rq.push_back(r_exp_t'{32'h0, AXI_RESP_OKAY});
        ar_send(16'h0004);
        drain();
        repeat (3) @(posedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
